// File: rtl/hub75_capture.sv
// hub75_capture: HUB75 panel-bus sniffer that rebuilds shifted rows and replays them as a valid/ready pixel stream.
// Optional HUB75_CAPTURE_ON_TIMER_EN adds on_cycles, the clk count of the last unblanked period.
module hub75_capture #(
    parameter int COLS        = 64,
    parameter int AB          = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              panel_rgb0,
    input  logic [2:0]              panel_rgb1,
    input  logic [AB-1:0]           panel_addr,
    input  logic                    panel_blank,
    input  logic                    panel_latch,
    input  logic                    panel_sclk,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [$clog2(COLS)-1:0] pix_x,
    output logic [AB-1:0]           pix_y,
    output logic [2:0]              pix_rgb0,
    output logic [2:0]              pix_rgb1,
    output logic                    pix_last,
    output logic [15:0]             row_count,
    output logic                    err_short,
    output logic                    err_overrun
`ifdef HUB75_CAPTURE_ON_TIMER_EN
    ,
    output logic [15:0]             on_cycles
`endif
);
    localparam int XW = $clog2(COLS);
    localparam int W  = AB + 9;
    localparam logic [W-1:0] RST_V = {1'b1, {(W-1){1'b0}}};
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, EMIT = 2'd2;

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] prev_q;
    logic [W-1:0] s;
    logic         sclk_rise, latch_rise, blank_fall;
    logic [5:0]   mem [2*COLS];
    logic [XW:0]  col, col_eff;
    logic         long_q, long_eff, fill, room, sclk_wr, row_ok;
    logic [1:0]   state;

    assign s          = sync_q[SYNC_STAGES-1];
    assign sclk_rise  = s[AB+6] & ~prev_q[AB+6];
    assign latch_rise = s[AB+7] & ~prev_q[AB+7];
    assign blank_fall = ~s[AB+8] & prev_q[AB+8];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RST_V;
            prev_q <= RST_V;
        end else begin
            sync_q[0] <= {panel_blank, panel_latch, panel_sclk, panel_addr, panel_rgb1, panel_rgb0};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= s;
        end
    end

    // An sclk rise in the same cycle as a latch rise is counted before the latch judges the row.
    assign room     = ~col[XW];
    assign sclk_wr  = sclk_rise & room;
    assign col_eff  = col + (XW+1)'(sclk_wr);
    assign long_eff = long_q | (sclk_rise & ~room);
    assign row_ok   = (col_eff == (XW+1)'(COLS)) && !long_eff;

    always_ff @(posedge clk) begin
        if (sclk_wr && !reset) mem[{fill, col[XW-1:0]}] <= s[5:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col         <= '0;
            long_q      <= 1'b0;
            fill        <= 1'b0;
            state       <= IDLE;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb0    <= '0;
            pix_rgb1    <= '0;
            row_count   <= '0;
            err_short   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_short   <= latch_rise && !row_ok;
            err_overrun <= latch_rise && row_ok && state != IDLE;
            col         <= latch_rise ? '0 : col_eff;
            long_q      <= latch_rise ? 1'b0 : long_eff;
            if (latch_rise && row_ok && state == IDLE) begin
                fill  <= ~fill;
                state <= ARMED;
            end
            // Output fields load straight from the emit buffer, addressed one beat ahead.
            if (state == ARMED && blank_fall) begin
                state                <= EMIT;
                pix_y                <= s[6 +: AB];
                pix_x                <= '0;
                {pix_rgb1, pix_rgb0} <= mem[{~fill, XW'(0)}];
            end else if (state == EMIT && pix_ready) begin
                if (pix_x == XW'(COLS-1)) begin
                    state     <= IDLE;
                    row_count <= row_count + 16'd1;
                end else begin
                    pix_x                <= pix_x + XW'(1);
                    {pix_rgb1, pix_rgb0} <= mem[{~fill, pix_x + XW'(1)}];
                end
            end
        end
    end

    assign pix_valid = state == EMIT;
    assign pix_last  = pix_valid && pix_x == XW'(COLS-1);

`ifdef HUB75_CAPTURE_ON_TIMER_EN
    logic [15:0] on_cnt;
    logic        blank_rise;

    assign blank_rise = s[AB+8] & ~prev_q[AB+8];

    // The fall cycle itself is already unblanked, so the count restarts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            on_cnt    <= '0;
            on_cycles <= '0;
        end else begin
            on_cnt <= blank_fall ? 16'd1 : (!s[AB+8] && on_cnt != 16'hFFFF) ? on_cnt + 16'd1 : on_cnt;
            if (blank_rise) on_cycles <= on_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: scoreboard bench for hub75_capture; expected beats are queued at stimulus time and popped by a monitor.
module tb_hub75_capture;
    logic        clk = 1'b0, reset = 1'b1;
    logic [2:0]  panel_rgb0 = '0, panel_rgb1 = '0;
    logic [4:0]  panel_addr = '0;
    logic        panel_blank = 1'b1, panel_latch = 1'b0, panel_sclk = 1'b0;
    logic        pix_valid, pix_ready = 1'b0, pix_last, err_short, err_overrun;
    logic [5:0]  pix_x;
    logic [4:0]  pix_y;
    logic [2:0]  pix_rgb0, pix_rgb1;
    logic [15:0] row_count;
`ifdef HUB75_CAPTURE_ON_TIMER_EN
    logic [15:0] on_cycles;
`endif

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
        logic [2:0] r0;
        logic [2:0] r1;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int n_tests = 0, n_fail = 0, n_short = 0, n_over = 0, ready_mode = 0;

    hub75_capture dut (
        .clk(clk), .reset(reset),
        .panel_rgb0(panel_rgb0), .panel_rgb1(panel_rgb1), .panel_addr(panel_addr),
        .panel_blank(panel_blank), .panel_latch(panel_latch), .panel_sclk(panel_sclk),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb0(pix_rgb0), .pix_rgb1(pix_rgb1), .pix_last(pix_last),
        .row_count(row_count), .err_short(err_short), .err_overrun(err_overrun)
`ifdef HUB75_CAPTURE_ON_TIMER_EN
        , .on_cycles(on_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready pattern 1-0-0-1 in mode 2.
    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = (ready_mode == 1) || (ready_mode == 2 && (k % 4 == 0 || k % 4 == 3));
            k++;
        end
    end

    // Monitor: every valid beat must match the scoreboard head; it is popped only when accepted.
    initial begin
        beat_t act;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (err_short) n_short++;
                if (err_overrun) n_over++;
                if (pix_valid) begin
                    act = {pix_x, pix_y, pix_rgb0, pix_rgb1, pix_last};
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL beat: unexpected beat %0h with empty scoreboard", act);
                    end else begin
                        if (act !== sb[0]) begin
                            n_fail++;
                            $display("FAIL beat: got x=%0d y=%0d rgb0=%0d rgb1=%0d last=%0d expected x=%0d y=%0d rgb0=%0d rgb1=%0d last=%0d",
                                     act.x, act.y, act.r0, act.r1, act.last,
                                     sb[0].x, sb[0].y, sb[0].r0, sb[0].r1, sb[0].last);
                        end
                        if (pix_ready) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift(input int n);
        for (int i = 0; i < n; i++) begin
            panel_rgb0 = i[2:0];
            panel_rgb1 = ~i[2:0];
            panel_sclk = 1'b0;
            tick(3);
            panel_sclk = 1'b1;
            tick(3);
        end
        panel_sclk = 1'b0;
        tick(3);
    endtask

    task automatic latch();
        panel_latch = 1'b1;
        tick(3);
        panel_latch = 1'b0;
        tick(3);
    endtask

    task automatic unblank(input int a, input int n);
        panel_addr  = 5'(a);
        panel_blank = 1'b0;
        tick(n);
        panel_blank = 1'b1;
        tick(6);
    endtask

    task automatic push_row(input int y);
        for (int x = 0; x < 64; x++) begin
            beat_t b;
            b.x = 6'(x);
            b.y = 5'(y);
            b.r0 = 3'(x);
            b.r1 = ~3'(x);
            b.last = (x == 63);
            sb.push_back(b);
        end
    endtask

    task automatic drain(input string name);
        logic done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            done = sb.size() == 0 && !pix_valid;
        end
        chk(name, done, 1'b1);
    endtask

    task automatic check_zero(input string name);
        chk(name, {pix_valid, pix_x, pix_y, pix_rgb0, pix_rgb1, pix_last, err_short, err_overrun}, 0);
        chk({name, "_rows"}, row_count, 0);
    endtask

    initial begin
        logic hit = 1'b0;
        tick(5);
        @(negedge clk);
        check_zero("reset_in");
        reset = 1'b0;
        tick(2);
        @(negedge clk);
        check_zero("reset_out");

        ready_mode = 1;
        shift(64);
        latch();
        push_row(5);
        unblank(5, 10);
        drain("normal_drain");
        chk("normal_rows", row_count, 1);

        ready_mode = 2;
        shift(64);
        latch();
        push_row(9);
        unblank(9, 10);
        drain("bp_drain");
        chk("bp_rows", row_count, 2);

        ready_mode = 1;
        shift(63);
        latch();
        tick(5);
        chk("short63", n_short, 1);
        shift(65);
        latch();
        tick(5);
        chk("long65", n_short, 2);
        unblank(4, 10);
        tick(20);
        chk("short_noemit_rows", row_count, 2);
        shift(64);
        latch();
        push_row(3);
        unblank(3, 10);
        drain("after_short_drain");
        chk("after_short_rows", row_count, 3);

        ready_mode = 0;
        shift(64);
        latch();
        push_row(7);
        unblank(7, 10);
        shift(64);
        latch();
        tick(5);
        chk("overrun_pulse", n_over, 1);
        ready_mode = 1;
        drain("overrun_drain");
        unblank(8, 10);
        tick(20);
        chk("overrun_rows", row_count, 4);
        chk("overrun_no_short", n_short, 2);

        shift(63);
        panel_rgb0 = 3'd7;
        panel_rgb1 = 3'd0;
        tick(3);
        panel_sclk  = 1'b1;
        panel_latch = 1'b1;
        tick(3);
        panel_sclk  = 1'b0;
        panel_latch = 1'b0;
        tick(3);
        chk("collide_no_short", n_short, 2);
        push_row(11);
        unblank(11, 10);
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            hit = pix_valid && pix_x == 6'd20;
        end
        chk("collide_reach20", hit, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midrow_reset");
        sb.delete();
        tick(2);
        reset = 1'b0;
        tick(2);
        shift(64);
        latch();
        push_row(12);
        unblank(12, 10);
        drain("post_reset_drain");
        chk("post_reset_rows", row_count, 1);
        chk("post_reset_over", n_over, 1);

`ifdef HUB75_CAPTURE_ON_TIMER_EN
        unblank(0, 300);
        tick(5);
        chk("on300", on_cycles, 300);
        unblank(0, 70000);
        tick(5);
        chk("on_sat", on_cycles, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
